sys_bus_arbiter: RTL and testbench
==================================

SYS_BUS_ARBITER -- requirements
Module: sys_bus_arbiter

Interface
REQ-001 Parameter MAXCYC, default 14: maximum number of ECLK cycles in one grant tenure (range 1..14).
REQ-002 Parameter ACKTO, default 16: number of ECLK cycles to wait for a CPU bus handshake before timing out.
REQ-003 ECLK  in  1  the only clock; all logic is on its rising edge.
REQ-004 RST  in  1  reset; synchronous and active-high.
REQ-005 BA  in  1  6809 bus-available status.
REQ-006 BS  in  1  6809 bus-status; BA=1 with BS=1 means the bus is granted.
REQ-007 REQ  in  2  requests from DMA requesters; bit n belongs to requester n; active-high and level-held.
REQ-008 CLR_ERR  in  1  clears ERR; a one-cycle pulse is enough.
REQ-009 BREQ_B  out  1  bus request to the 6809 DMA/BREQ pin; active-low.
REQ-010 GNT  out  2  one-hot bus grant to the requesters.
REQ-011 ERR  out  1  sticky flag: a handshake timed out.
REQ-012 All outputs are registered.

Function
REQ-013 The state machine has four states: IDLE, WAITBA, GRANT, RELEASE.
REQ-014 IDLE: BREQ_B=1 and GNT=00. When REQ is nonzero, latch a winner W, go to WAITBA, and drive BREQ_B=0 from the next cycle.
REQ-015 Winner selection:
- one requester active: that requester wins.
- both active: round-robin; the requester other than LAST wins.
- LAST is updated to W when the machine leaves GRANT.
REQ-016 WAITBA: BREQ_B=0.
- BA=1 and BS=1 sampled: go to GRANT; GNT[W]=1 from the next cycle; tenure counter cleared to 0.
- REQ[W]=0 sampled first: go to RELEASE without issuing any grant.
REQ-017 GRANT: BREQ_B=0, GNT[W]=1, and the tenure counter increments every cycle. Go to RELEASE when either holds:
- REQ[W]=0, or
- the counter equals MAXCYC-1.
On the transition, GNT=00 and BREQ_B=1 on the next cycle.
REQ-018 A tenure therefore lasts at most MAXCYC GNT-high cycles. This preserves the 6809 refresh/steal-back cycle.
REQ-019 A requester still asserting after a MAXCYC cutoff is not granted again until it wins a fresh arbitration from IDLE.
REQ-020 RELEASE: BREQ_B=1 and GNT=00. Go to IDLE when BA=0 is sampled.
REQ-021 GNT never has more than one bit set. GNT is never 1 unless BA=BS=1 was sampled in that tenure.
REQ-022 REQ changes during WAITBA or RELEASE for a requester other than W are ignored until IDLE.
REQ-023 The counter saturates and never wraps.

Reset
REQ-024 RST=1 on an ECLK edge forces these values on the next cycle, from any state, including mid-tenure:
- state=IDLE
- BREQ_B=1
- GNT=00
- ERR=0
- LAST=1, so requester 0 wins the first tie
- all counters=0
REQ-025 The arbiter responds to REQ in the first cycle after RST deasserts.

Configuration
REQ-026 Macro SYS_ARB_TIMEOUT_EN defined:
- a timeout counter runs in WAITBA and in RELEASE.
- when ACKTO cycles elapse without the awaited condition, ERR is set and the state goes to RELEASE (from WAITBA) or to IDLE (from RELEASE).
- ERR is cleared by CLR_ERR. If a timeout and CLR_ERR occur in the same cycle, set wins.
REQ-027 Macro SYS_ARB_TIMEOUT_EN not defined:
- WAITBA and RELEASE wait indefinitely.
- ERR is tied to 0.
- no timeout counter logic is synthesised.

Verification
REQ-028 Single request: REQ=01 at cycle 0; BA=BS=1 from cycle 3; REQ=00 at cycle 8 -> BREQ_B low at cycle 1; GNT=01 at cycles 4..8; BREQ_B high at cycle 9; IDLE after BA=0.
REQ-029 Tenure cap: REQ=10 held with BA=BS=1 and MAXCYC=14 -> GNT=10 for exactly 14 cycles, then BREQ_B=1 and GNT=00.
REQ-030 Round-robin: REQ=11 held across three arbitrations from reset -> winners are 0, then 1, then 0.
REQ-031 Abort: REQ=01, then REQ drops in WAITBA before BA=BS=1 -> GNT stays 00; goes to RELEASE, then IDLE.
REQ-032 Timeout, SYS_ARB_TIMEOUT_EN defined, ACKTO=16: BA held 0 after a request -> ERR=1 after 16 WAITBA cycles and BREQ_B=1; CLR_ERR pulse -> ERR=0.
REQ-033 Reset mid-GRANT: RST=1 while GNT=01 -> next cycle GNT=00, BREQ_B=1, state IDLE; REQ=11 after reset -> requester 0 wins.

Source files
------------

// File: rtl/sys_bus_arbiter.sv
// rtl/sys_bus_arbiter.sv - two-requester 6809 DMA bus arbiter with tenure cap; optional handshake timeout under SYS_ARB_TIMEOUT_EN
module sys_bus_arbiter #(
    parameter int MAXCYC = 14,
    parameter int ACKTO  = 16
) (
    input  logic       ECLK,
    input  logic       RST,
    input  logic       BA,
    input  logic       BS,
    input  logic [1:0] REQ,
    input  logic       CLR_ERR,
    output logic       BREQ_B,
    output logic [1:0] GNT,
    output logic       ERR
);

    typedef enum logic [1:0] {S_IDLE, S_WAITBA, S_GRANT, S_RELEASE} state_t;

    localparam logic [3:0] TEN_LAST = 4'(MAXCYC - 1);

    state_t     r_state, w_next;
    logic       r_win, w_win_next;
    logic       r_last, w_last_next;
    logic [3:0] r_ten, w_ten_next;
    logic       r_breq_b;
    logic [1:0] r_gnt;
    logic       w_timeout;
    logic       w_set_err;

    always_comb begin
        w_next      = r_state;
        w_win_next  = r_win;
        w_last_next = r_last;
        w_ten_next  = r_ten;
        w_set_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (REQ != 2'b00) begin
                    w_next     = S_WAITBA;
                    w_win_next = (REQ == 2'b11) ? ~r_last : REQ[1];
                end
            end
            S_WAITBA: begin
                // A dropped request wins over a simultaneous bus grant so no stale GNT is issued
                if (!REQ[r_win]) begin
                    w_next = S_RELEASE;
                end else if (BA && BS) begin
                    w_next     = S_GRANT;
                    w_ten_next = 4'd0;
                end else if (w_timeout) begin
                    w_next    = S_RELEASE;
                    w_set_err = 1'b1;
                end
            end
            S_GRANT: begin
                if (r_ten != 4'hF) begin
                    w_ten_next = r_ten + 4'd1;
                end
                if (!REQ[r_win] || r_ten >= TEN_LAST) begin
                    w_next      = S_RELEASE;
                    w_last_next = r_win;
                end
            end
            S_RELEASE: begin
                if (!BA) begin
                    w_next = S_IDLE;
                end else if (w_timeout) begin
                    w_next    = S_IDLE;
                    w_set_err = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ECLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_win    <= 1'b0;
            r_last   <= 1'b1;
            r_ten    <= 4'd0;
            r_breq_b <= 1'b1;
            r_gnt    <= 2'b00;
        end else begin
            r_state  <= w_next;
            r_win    <= w_win_next;
            r_last   <= w_last_next;
            r_ten    <= w_ten_next;
            r_breq_b <= !(w_next == S_WAITBA || w_next == S_GRANT);
            r_gnt    <= (w_next == S_GRANT) ? (w_win_next ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    assign BREQ_B = r_breq_b;
    assign GNT    = r_gnt;

`ifdef SYS_ARB_TIMEOUT_EN
    localparam int TOW = $clog2(ACKTO + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(ACKTO - 1);

    logic [TOW-1:0] r_to;
    logic           r_err;

    assign w_timeout = (r_state == S_WAITBA || r_state == S_RELEASE) && (r_to == TO_LAST);

    // Cleared on every state change so each wait gets a full ACKTO window
    always_ff @(posedge ECLK) begin
        if (RST) begin
            r_to <= '0;
        end else if (w_next != r_state) begin
            r_to <= '0;
        end else if ((r_state == S_WAITBA || r_state == S_RELEASE) && r_to != {TOW{1'b1}}) begin
            r_to <= r_to + 1'b1;
        end
    end

    always_ff @(posedge ECLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_set_err) begin
            r_err <= 1'b1;
        end else if (CLR_ERR) begin
            r_err <= 1'b0;
        end
    end

    assign ERR = r_err;
`else
    logic w_unused;

    assign w_timeout = 1'b0;
    assign ERR       = 1'b0;
    assign w_unused  = CLR_ERR ^ w_set_err ^ (ACKTO > 0);
`endif

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb/tb_sys_bus_arbiter.sv - scoreboard bench for sys_bus_arbiter with directed per-cycle vectors
module tb_sys_bus_arbiter;

    logic       ECLK = 1'b0;
    logic       RST = 1'b1;
    logic       BA = 1'b0;
    logic       BS = 1'b0;
    logic [1:0] REQ = 2'b00;
    logic       CLR_ERR = 1'b0;
    logic       BREQ_B;
    logic [1:0] GNT;
    logic       ERR;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       breq_b;
        logic [1:0] gnt;
        logic       err;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];

    sys_bus_arbiter #(.MAXCYC(14), .ACKTO(16)) dut (
        .ECLK    (ECLK),
        .RST     (RST),
        .BA      (BA),
        .BS      (BS),
        .REQ     (REQ),
        .CLR_ERR (CLR_ERR),
        .BREQ_B  (BREQ_B),
        .GNT     (GNT),
        .ERR     (ERR)
    );

    always #5 ECLK = ~ECLK;

    // Inputs for cycle k are driven just after edge k; expected outputs are those produced by edge k
    task automatic cyc(input logic rst, input logic [1:0] req, input logic bus, input logic clr,
                       input logic eb, input logic [1:0] eg, input logic ee, input string nm);
        exp_t e;
        @(posedge ECLK);
        #1;
        RST     = rst;
        REQ     = req;
        BA      = bus;
        BS      = bus;
        CLR_ERR = clr;
        e.breq_b = eb;
        e.gnt    = eg;
        e.err    = ee;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    // Full tenure starting in IDLE: wait_n WAITBA cycles with BA=0, then gcyc GNT cycles, then release
    task automatic tenure(input logic [1:0] req, input int w, input int wait_n, input int gcyc,
                          input logic drop, input string nm);
        logic [1:0] g;
        logic [1:0] rq;
        g = (w == 0) ? 2'b01 : 2'b10;
        cyc(1'b0, req, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, {nm, "_idle"});
        for (int i = 0; i < wait_n; i++)
            cyc(1'b0, req, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, {nm, "_waitba"});
        cyc(1'b0, req, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, {nm, "_waitba_ba"});
        for (int i = 0; i < gcyc; i++) begin
            rq = (drop && i == gcyc - 1) ? 2'b00 : req;
            cyc(1'b0, rq, 1'b1, 1'b0, 1'b0, g, 1'b0, {nm, "_grant"});
        end
        rq = drop ? 2'b00 : req;
        cyc(1'b0, rq, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, {nm, "_release"});
        cyc(1'b0, rq, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, {nm, "_release_ba0"});
    endtask

    initial begin : monitor
        exp_t  e;
        string n;
        forever begin
            @(negedge ECLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                n_cmp++;
                if ({BREQ_B, GNT, ERR} !== e) begin
                    n_err++;
                    $display("FAIL %s: got breq_b=%b gnt=%b err=%b, expected breq_b=%b gnt=%b err=%b",
                             n, BREQ_B, GNT, ERR, e.breq_b, e.gnt, e.err);
                end
            end
        end
    end

    initial begin : stimulus
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "reset");
        cyc(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "reset");

        tenure(2'b01, 0, 2, 5, 1'b1, "single");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "single_back_idle");

        tenure(2'b10, 1, 1, 14, 1'b0, "cap");
        tenure(2'b11, 0, 0, 14, 1'b0, "rr_first");
        tenure(2'b11, 1, 0, 14, 1'b0, "rr_second");
        tenure(2'b11, 0, 0, 3, 1'b1, "rr_third");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "rr_back_idle");

        cyc(1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "abort_idle");
        cyc(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "abort_waitba");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "abort_drop");
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, "abort_release");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "abort_release_ba0");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "abort_idle_after");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "abort_idle_after");

`ifdef SYS_ARB_TIMEOUT_EN
        cyc(1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "to_idle");
        for (int i = 0; i < 16; i++)
            cyc(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, "to_waitba");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, "to_err_release");
        cyc(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, "to_err_held");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "to_err_cleared");
`endif

        cyc(1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "rstg_idle");
        cyc(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "rstg_waitba");
        cyc(1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, "rstg_grant");
        cyc(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, "rstg_grant_rst");
        cyc(1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, "rstg_after_rst");
        cyc(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, "rstg_waitba2");
        cyc(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, "rstg_tie_win0");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "rstg_release");
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, "rstg_idle_end");

        repeat (3) @(posedge ECLK);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
